// File: rtl/socket_pkg.sv
// Shared definitions for the socket buffer: default word width, width helpers
// and the occupancy flag states.
package socket_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FRAME,
        SATURATED
    } flag_state_t;

endpackage

// File: rtl/socket_ram.sv
// Simple dual-port synchronous RAM: one write port and one registered read port
// whose output register holds its value between reads.
module socket_ram
    import socket_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 8,
    parameter int AW         = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A same-address read and write returns the old word, which the full-buffer
    // read-while-write case relies on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/socket_buffer.sv
// Frame-oriented circular buffer between an upstream processing stage and a
// downstream socket controller, with registered occupancy flags.
module socket_buffer
    import socket_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int SOCKET_SIZE = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_dv,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_dv,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_wr_ready,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int DEPTH = 2 * SOCKET_SIZE;
    localparam int CW    = count_width(DEPTH);
    localparam int PW    = ptr_width(DEPTH);

    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] FRAME_C   = CW'(SOCKET_SIZE);
    localparam logic [CW-1:0] PARTIAL_C = CW'(SOCKET_SIZE - 1);
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          rd_ok;
    logic          wr_ok;
    flag_state_t   state;
    flag_state_t   state_next;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // A full buffer still accepts a write when a read frees a slot in the same cycle.
    always_comb begin
        rd_ok      = i_rd_en && (count != '0);
        wr_ok      = i_dv && ((count != DEPTH_C) || rd_ok);
        count_next = count;
        if (wr_ok && !rd_ok) begin
            count_next = count + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            o_dv        <= 1'b0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            count <= count_next;
            o_dv  <= rd_ok;
            if (wr_ok) begin
                wr_ptr <= wrap_inc(wr_ptr);
            end
            if (rd_ok) begin
                rd_ptr <= wrap_inc(rd_ptr);
            end
            if (i_dv && !wr_ok) begin
                o_overflow <= 1'b1;
            end
            if (i_rd_en && (count == '0)) begin
                o_underflow <= 1'b1;
            end
        end
    end

    socket_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (PW)
    ) u_ram (
        .clk     (i_clk),
        .rst_n   (i_rst),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr),
        .wr_data (i_data),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr),
        .rd_data (o_data)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Count moves by at most one per cycle, so each state only checks its neighbours.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (count_next != '0) state_next = PARTIAL;
            end
            PARTIAL: begin
                if (count_next == '0)          state_next = EMPTY;
                else if (count_next == FRAME_C) state_next = FRAME;
            end
            FRAME: begin
                if (count_next == PARTIAL_C)    state_next = PARTIAL;
                else if (count_next == DEPTH_C) state_next = SATURATED;
            end
            SATURATED: begin
                if (count_next != DEPTH_C) state_next = FRAME;
            end
            default: state_next = EMPTY;
        endcase
    end

    always_comb begin
        o_empty    = 1'b0;
        o_full     = 1'b0;
        o_wr_ready = 1'b1;
        case (state)
            EMPTY:     o_empty = 1'b1;
            FRAME:     o_full  = 1'b1;
            SATURATED: begin
                o_full     = 1'b1;
                o_wr_ready = 1'b0;
            end
            default: ;
        endcase
    end

endmodule
